instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit_pkg.sv | 17 +
 rtl/instruction_fetch_unit_if.sv | 27 ++
 rtl/instruction_fetch_unit_fifo.sv | 52 +++++
 rtl/instruction_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types for the instruction fetch front end.
// Bubble encoding, fetch state and prefetch entry layout.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fifo_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory request/response channel.
// master = fetch unit, slave = memory.
interface instruction_fetch_unit_if;

  logic        imem_req_valid_out;
  logic        imem_req_ready_in;
  logic [63:0] imem_addr_out;
  logic        imem_rsp_valid_in;
  logic [31:0] imem_rsp_data_in;

  modport master (
    output imem_req_valid_out,
    output imem_addr_out,
    input  imem_req_ready_in,
    input  imem_rsp_valid_in,
    input  imem_rsp_data_in
  );

  modport slave (
    input  imem_req_valid_out,
    input  imem_addr_out,
    output imem_req_ready_in,
    output imem_rsp_valid_in,
    output imem_rsp_data_in
  );

endinterface

// File: rtl/instruction_fetch_unit_fifo.sv
// Prefetch FIFO: push/pop/clear with occupancy count.
// Storage is not reset; pointers and count are.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  fifo_entry_t din,
  output fifo_entry_t dout,
  output logic [CW-1:0] count,
  output logic        full,
  output logic        empty
);

  fifo_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign dout  = mem_q[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk_in) begin
    if (push && !clear) begin
      mem_q[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: in-order imem requests, prefetch buffer,
// redirect (branch/irq/mret) with stale-response drain.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_signal_in,
  input  logic        redirect_signal_in,
  input  logic [63:0] redirect_pc_in,
  input  logic        interrupt_signal_in,
  input  logic [63:0] mtvec_in,
  input  logic        return_interrupt_signal_in,
  input  logic [63:0] csr_mepc_in,
  instruction_fetch_unit_if.master imem,
  output logic [31:0] instr_out,
  output logic [63:0] pc_out,
  output logic        flush_signal_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e      state;
  logic        irq_q;
  logic [63:0] fetch_pc;
  logic [63:0] resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_next;

  logic        irq_rise;
  logic        redir;
  logic [63:0] target;
  logic [CW:0] inflight;
  logic        req_valid;
  logic        accept;
  logic        rsp_dec;

  logic        f_push;
  logic        f_pop;
  logic        f_full;
  logic        f_empty;
  logic [CW-1:0] f_count;
  fifo_entry_t f_din;
  fifo_entry_t f_dout;

  always_comb begin
    irq_rise = interrupt_signal_in & ~irq_q;
    redir    = irq_rise
             | return_interrupt_signal_in
             | redirect_signal_in;
    if (irq_rise) begin
      target = mtvec_in;
    end else if (return_interrupt_signal_in) begin
      target = csr_mepc_in;
    end else begin
      target = redirect_pc_in;
    end
    target = target & ~64'h3;
  end

  // fifo + outstanding is the credit bound: no overflow
  assign inflight = {1'b0, f_count} + {1'b0, outstanding};
  assign req_valid = !rst_in && state == RUN && !redir
                   && !f_full
                   && inflight < (CW+1)'(FIFO_DEPTH);
  assign accept  = req_valid & imem.imem_req_ready_in;
  assign rsp_dec = imem.imem_rsp_valid_in
                 && outstanding != '0;
  assign out_next = outstanding + CW'(accept) - CW'(rsp_dec);

  assign imem.imem_req_valid_out = req_valid;
  assign imem.imem_addr_out      = fetch_pc;

  assign f_push = state == RUN && !redir
                && imem.imem_rsp_valid_in;
  assign f_pop  = !redir && !stall_signal_in && !f_empty;
  assign f_din  = '{pc: resp_pc, instr: imem.imem_rsp_data_in};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (f_push),
    .pop    (f_pop),
    .clear  (redir),
    .din    (f_din),
    .dout   (f_dout),
    .count  (f_count),
    .full   (f_full),
    .empty  (f_empty)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= RUN;
      irq_q            <= 1'b0;
      fetch_pc         <= RESET_PC;
      resp_pc          <= RESET_PC;
      outstanding      <= '0;
      instr_out        <= NOP_INSTR;
      pc_out           <= 64'h0;
      flush_signal_out <= 1'b0;
    end else begin
      irq_q       <= interrupt_signal_in;
      outstanding <= out_next;
      if (redir) begin
        fetch_pc         <= target;
        resp_pc          <= target;
        instr_out        <= NOP_INSTR;
        flush_signal_out <= 1'b1;
        // a redirect in DRAIN keeps draining
        if (out_next != '0 || state == DRAIN) begin
          state <= DRAIN;
        end
      end else begin
        flush_signal_out <= 1'b0;
        if (accept) fetch_pc <= fetch_pc + 64'd4;
        if (f_push) resp_pc  <= resp_pc + 64'd4;
        if (!stall_signal_in) begin
          if (!f_empty) begin
            instr_out <= f_dout.instr;
            pc_out    <= f_dout.pc;
          end else begin
            instr_out <= NOP_INSTR;
          end
        end
        if (state == DRAIN && out_next == '0) begin
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: in-order memory model plus
// a stream-level model of the expected PC/instruction sequence.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        stall_signal_in = 1'b0;
  logic        redirect_signal_in = 1'b0;
  logic [63:0] redirect_pc_in = '0;
  logic        interrupt_signal_in = 1'b0;
  logic [63:0] mtvec_in = '0;
  logic        return_interrupt_signal_in = 1'b0;
  logic [63:0] csr_mepc_in = '0;
  logic [31:0] instr_out;
  logic [63:0] pc_out;
  logic        flush_signal_out;

  instruction_fetch_unit_if imem ();

  instruction_fetch_unit dut (
    .clk_in                     (clk_in),
    .rst_in                     (rst_in),
    .stall_signal_in            (stall_signal_in),
    .redirect_signal_in         (redirect_signal_in),
    .redirect_pc_in             (redirect_pc_in),
    .interrupt_signal_in        (interrupt_signal_in),
    .mtvec_in                   (mtvec_in),
    .return_interrupt_signal_in (return_interrupt_signal_in),
    .csr_mepc_in                (csr_mepc_in),
    .imem                       (imem),
    .instr_out                  (instr_out),
    .pc_out                     (pc_out),
    .flush_signal_out           (flush_signal_out)
  );

  always #5 clk_in = ~clk_in;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_vec = 0;
  int n_err = 0;

  bit          nx_stall, nx_redir, nx_irq, nx_mret;
  logic [63:0] nx_rpc, nx_mtvec, nx_mepc;
  int          rdy_pct, rsp_pct;

  logic [63:0] pend[$];
  logic [63:0] exp_pc, exp_req, prev_pc, tgt_prev;
  logic [31:0] prev_instr;
  int          stale;
  bit          irq_m, ev_prev, stall_prev, found;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h0010_0093;
    if (a == 64'h4) return 32'h0020_0113;
    return {a[30:2], 3'b111};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit          ev;
    logic [63:0] tgt;
    int          stale_before;
    @(negedge clk_in);
    if (ev_prev) begin
      chk("flush_on_redir", 64'(flush_signal_out), 64'd1);
      chk("nop_on_redir", 64'(instr_out), 64'(NOP));
      exp_pc = tgt_prev;
    end else begin
      chk("flush_idle", 64'(flush_signal_out), 64'd0);
      if (stall_prev) begin
        chk("stall_instr", 64'(instr_out), 64'(prev_instr));
        chk("stall_pc", pc_out, prev_pc);
      end else if (instr_out !== NOP) begin
        chk("stream_pc", pc_out, exp_pc);
        chk("stream_instr", 64'(instr_out),
            64'(mem_word(exp_pc)));
        exp_pc = exp_pc + 64'd4;
      end else begin
        chk("bubble_pc", pc_out, prev_pc);
      end
    end
    prev_instr = instr_out;
    prev_pc    = pc_out;
    stale_before = stale;
    if (pend.size() > 0 && $urandom_range(99) < rsp_pct) begin
      imem.imem_rsp_valid_in = 1'b1;
      imem.imem_rsp_data_in  = mem_word(pend.pop_front());
      if (stale > 0) stale--;
    end else begin
      imem.imem_rsp_valid_in = 1'b0;
      imem.imem_rsp_data_in  = $urandom();
    end
    imem.imem_req_ready_in = ($urandom_range(99) < rdy_pct);
    stall_signal_in            = nx_stall;
    redirect_signal_in         = nx_redir;
    redirect_pc_in             = nx_rpc;
    interrupt_signal_in        = nx_irq;
    mtvec_in                   = nx_mtvec;
    return_interrupt_signal_in = nx_mret;
    csr_mepc_in                = nx_mepc;
    ev = (nx_irq && !irq_m) || nx_mret || nx_redir;
    if (nx_irq && !irq_m) tgt = nx_mtvec;
    else if (nx_mret)     tgt = nx_mepc;
    else                  tgt = nx_rpc;
    tgt[1:0] = 2'b00;
    irq_m = nx_irq;
    #1;
    if (ev)
      chk("no_req_on_redir",
          64'(imem.imem_req_valid_out), 64'd0);
    if (stale_before > 0)
      chk("no_req_in_drain",
          64'(imem.imem_req_valid_out), 64'd0);
    if (imem.imem_req_valid_out && imem.imem_req_ready_in) begin
      chk("req_addr", imem.imem_addr_out, exp_req);
      exp_req = exp_req + 64'd4;
      pend.push_back(imem.imem_addr_out);
    end
    if (ev) begin
      exp_req = tgt;
      stale   = pend.size();
    end
    ev_prev    = ev;
    tgt_prev   = tgt;
    stall_prev = nx_stall;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    imem.imem_req_ready_in = 1'b0;
    imem.imem_rsp_valid_in = 1'b0;
    imem.imem_rsp_data_in  = '0;
    {nx_stall, nx_redir, nx_irq, nx_mret} = '0;
    stall_signal_in = 0; redirect_signal_in = 0;
    interrupt_signal_in = 0; return_interrupt_signal_in = 0;
    pend.delete();
    exp_pc = 64'h0; exp_req = 64'h0; prev_pc = 64'h0;
    prev_instr = NOP; stale = 0; irq_m = 0;
    ev_prev = 0; stall_prev = 0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic wait_instr();
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (instr_out !== NOP) found = 1;
    end
    chk("instr_timeout", 64'(found), 64'd1);
  endtask

  initial begin
    nx_rpc = '0; nx_mtvec = '0; nx_mepc = '0;
    rdy_pct = 100; rsp_pct = 100;
    @(negedge clk_in);
    chk("rst_instr", 64'(instr_out), 64'(NOP));
    chk("rst_pc", pc_out, 64'h0);
    chk("rst_flush", 64'(flush_signal_out), 64'd0);
    chk("rst_req", 64'(imem.imem_req_valid_out), 64'd0);
    do_reset();

    // startup stream
    repeat (3) step();
    chk("t1_nop", 64'(instr_out), 64'(NOP));
    step();
    chk("t1_pc0", pc_out, 64'h0);
    chk("t1_i0", 64'(instr_out), 64'h0010_0093);
    step();
    chk("t1_pc4", pc_out, 64'h4);
    chk("t1_i1", 64'(instr_out), 64'h0020_0113);

    // three stall cycles
    nx_stall = 1;
    step();
    chk("t2_pc8", pc_out, 64'h8);
    step();
    step();
    chk("t2_hold", pc_out, 64'h8);
    nx_stall = 0;
    step();
    chk("t2_hold3", pc_out, 64'h8);
    chk("t2_credit", 64'(imem.imem_req_valid_out), 64'd0);
    step();
    chk("t2_resume", pc_out, 64'hC);

    // branch with responses in flight
    rsp_pct = 0;
    step();
    nx_redir = 1; nx_rpc = 64'h1002;
    step();
    nx_redir = 0; rsp_pct = 100;
    step();
    chk("t3_flush", 64'(flush_signal_out), 64'd1);
    step();
    chk("t3_flush_1cyc", 64'(flush_signal_out), 64'd0);
    wait_instr();
    chk("t3_target", pc_out, 64'h1000);

    // interrupt beats branch; held level is not a new edge
    nx_irq = 1; nx_mtvec = 64'h200;
    nx_redir = 1; nx_rpc = 64'h80;
    step();
    nx_redir = 0;
    wait_instr();
    chk("t4_mtvec", pc_out, 64'h200);
    repeat (4) step();
    nx_mret = 1; nx_mepc = 64'h44;
    step();
    nx_mret = 0;
    wait_instr();
    chk("t4_mepc", pc_out, 64'h44);
    nx_irq = 0;
    repeat (3) step();

    // memory not ready
    rdy_pct = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_valid", 64'(imem.imem_req_valid_out), 64'd1);
      chk("t5_addr", imem.imem_addr_out, exp_req);
    end
    chk("t5_drained", 64'(instr_out), 64'(NOP));
    rdy_pct = 100;

    // pc wrap
    nx_redir = 1; nx_rpc = 64'hFFFF_FFFF_FFFF_FFF9;
    step();
    nx_redir = 0;
    wait_instr();
    chk("wrap_start", pc_out, 64'hFFFF_FFFF_FFFF_FFF8);
    repeat (4) step();
    chk("wrap_end", pc_out, 64'h8);

    // async reset during drain
    rsp_pct = 0;
    repeat (8) step();
    nx_redir = 1; nx_rpc = 64'h3000;
    step();
    nx_redir = 0; rsp_pct = 100;
    step();
    rsp_pct = 0;
    step();
    chk("t6_stale3", 64'(stale), 64'd3);
    rst_in = 1'b1;
    #1;
    chk("t6_instr", 64'(instr_out), 64'(NOP));
    chk("t6_pc", pc_out, 64'h0);
    chk("t6_flush", 64'(flush_signal_out), 64'd0);
    chk("t6_req", 64'(imem.imem_req_valid_out), 64'd0);
    do_reset();
    rsp_pct = 100;
    wait_instr();
    chk("t6_restart", pc_out, 64'h0);

    // randomized traffic
    rdy_pct = 70; rsp_pct = 60;
    for (int i = 0; i < 600; i++) begin
      nx_stall = ($urandom_range(99) < 25);
      nx_redir = ($urandom_range(99) < 4);
      nx_mret  = ($urandom_range(99) < 2);
      if ($urandom_range(99) < 5) nx_irq = !nx_irq;
      nx_rpc   = {$urandom(), $urandom()};
      nx_mepc  = {$urandom(), $urandom()};
      nx_mtvec = {$urandom(), $urandom()};
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
